// File: rtl/id_pkg.sv
// Shared decode constants and the decoded-instruction bundle for the ID stage.
package id_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef enum logic [7:0] {
    ALU_NOP = 8'h00,
    ALU_OR  = 8'h25,
    ALU_AND = 8'h24,
    ALU_XOR = 8'h26,
    ALU_NOR = 8'h27,
    ALU_ADD = 8'h20,
    ALU_SUB = 8'h22,
    ALU_SLL = 8'h7C,
    ALU_SRL = 8'h02,
    ALU_SRA = 8'h03
  } aluop_e;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_SHIFT = 3'b010,
    SEL_ARITH = 3'b100
  } alusel_e;

  typedef struct packed {
    aluop_e      aluop;
    alusel_e     alusel;
    logic        rd1_en;
    logic        rd2_en;
    logic [31:0] imm;
    logic [4:0]  wd;
    logic        wreg;
    logic        illegal;
  } id_dec_t;

endpackage

// File: rtl/id_decoder.sv
// Pure combinational decode of one instruction word into the ID bundle.
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] inst_i,
  output id_dec_t     dec_o
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] sa;
  logic [5:0] funct;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];

  // Field decode; anything not matched falls through as illegal with no reads/writes.
  always_comb begin
    dec_o.aluop   = ALU_NOP;
    dec_o.alusel  = SEL_NOP;
    dec_o.rd1_en  = 1'b0;
    dec_o.rd2_en  = 1'b0;
    dec_o.imm     = 32'h0;
    dec_o.wd      = 5'd0;
    dec_o.wreg    = 1'b0;
    dec_o.illegal = 1'b1;
    unique case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_o.aluop   = (op == OP_ORI)  ? ALU_OR :
                        (op == OP_ANDI) ? ALU_AND : ALU_XOR;
        dec_o.alusel  = SEL_LOGIC;
        dec_o.rd1_en  = 1'b1;
        dec_o.imm     = {16'h0, inst_i[15:0]};
        dec_o.wd      = rt;
        dec_o.wreg    = 1'b1;
        dec_o.illegal = 1'b0;
      end
      OP_ADDI: begin
        dec_o.aluop   = ALU_ADD;
        dec_o.alusel  = SEL_ARITH;
        dec_o.rd1_en  = 1'b1;
        dec_o.imm     = {{16{inst_i[15]}}, inst_i[15:0]};
        dec_o.wd      = rt;
        dec_o.wreg    = 1'b1;
        dec_o.illegal = 1'b0;
      end
      OP_LUI: begin
        dec_o.aluop   = ALU_OR;
        dec_o.alusel  = SEL_LOGIC;
        dec_o.imm     = {inst_i[15:0], 16'h0};
        dec_o.wd      = rt;
        dec_o.wreg    = 1'b1;
        dec_o.illegal = 1'b0;
      end
      OP_SPECIAL: begin
        unique case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            unique case (funct)
              FN_ADD:  dec_o.aluop = ALU_ADD;
              FN_SUB:  dec_o.aluop = ALU_SUB;
              FN_AND:  dec_o.aluop = ALU_AND;
              FN_OR:   dec_o.aluop = ALU_OR;
              FN_XOR:  dec_o.aluop = ALU_XOR;
              default: dec_o.aluop = ALU_NOR;
            endcase
            dec_o.alusel  = (funct == FN_ADD || funct == FN_SUB) ? SEL_ARITH : SEL_LOGIC;
            dec_o.rd1_en  = 1'b1;
            dec_o.rd2_en  = 1'b1;
            dec_o.wd      = rd;
            dec_o.wreg    = 1'b1;
            dec_o.illegal = 1'b0;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shifts with a nonzero rs field are not valid encodings.
            if (rs == 5'd0) begin
              dec_o.aluop   = (funct == FN_SLL) ? ALU_SLL :
                              (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
              dec_o.alusel  = SEL_SHIFT;
              dec_o.rd2_en  = 1'b1;
              dec_o.imm     = {27'h0, sa};
              dec_o.wd      = rd;
              dec_o.wreg    = 1'b1;
              dec_o.illegal = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: decode, EX/MEM operand forwarding, load-use
// stall detection and the ID/EX output register with valid/ready/flush.
module id_fwd_stage
  import id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [DATA_W-1:0]   pc_i,
  input  logic [31:0]         inst_i,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush_i,
  input  logic                ex_ready_i,
  output logic                id_valid_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   pc_o,
  output logic                illegal_o,
  output logic                stall_req_o
);

  id_dec_t              dec;
  logic [REG_AW-1:0]    addr1;
  logic [REG_AW-1:0]    addr2;
  logic [DATA_W-1:0]    imm_w;
  logic [DATA_W-1:0]    reg1_d, reg2_d;
  logic                 load_hit;
  logic                 accept;

  logic                 valid_q;
  logic [ALUOP_W-1:0]   aluop_q;
  logic [ALUSEL_W-1:0]  alusel_q;
  logic [DATA_W-1:0]    reg1_q, reg2_q, pc_q;
  logic [REG_AW-1:0]    wd_q;
  logic                 wreg_q, illegal_q;

  id_decoder u_decoder (
    .inst_i (inst_i),
    .dec_o  (dec)
  );

  assign addr1       = REG_AW'(inst_i[25:21]);
  assign addr2       = REG_AW'(inst_i[20:16]);
  assign reg1_read_o = dec.rd1_en;
  assign reg2_read_o = dec.rd2_en;
  assign reg1_addr_o = addr1;
  assign reg2_addr_o = addr2;
  assign imm_w       = DATA_W'(dec.imm);

  // Operand select: immediate, $0, EX bypass, MEM bypass, then regfile.
  // Port 2 only carries the immediate when port 1 reads a register; LUI
  // (no reads) puts its constant on port 1 and zero on port 2.
  always_comb begin
    reg1_d = imm_w;
    if (dec.rd1_en) begin
      if (addr1 == '0)                                      reg1_d = '0;
      else if (FWD_EN && ex_wreg_i && (ex_wd_i == addr1))   reg1_d = ex_wdata_i;
      else if (FWD_EN && mem_wreg_i && (mem_wd_i == addr1)) reg1_d = mem_wdata_i;
      else                                                  reg1_d = reg1_data_i;
    end
    reg2_d = dec.rd1_en ? imm_w : '0;
    if (dec.rd2_en) begin
      if (addr2 == '0)                                      reg2_d = '0;
      else if (FWD_EN && ex_wreg_i && (ex_wd_i == addr2))   reg2_d = ex_wdata_i;
      else if (FWD_EN && mem_wreg_i && (mem_wd_i == addr2)) reg2_d = mem_wdata_i;
      else                                                  reg2_d = reg2_data_i;
    end
  end

  // A load result cannot be bypassed in time, so any read of its target stalls.
  assign load_hit    = (dec.rd1_en && (addr1 == ex_wd_i)) || (dec.rd2_en && (addr2 == ex_wd_i));
  assign stall_req_o = if_valid_i && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) && load_hit;
  assign if_ready_o  = !stall_req_o && (!valid_q || ex_ready_i);
  assign accept      = if_valid_i && if_ready_o;

  // ID/EX register: flush beats accept beats drain; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      aluop_q   <= ALUOP_W'(ALU_NOP);
      alusel_q  <= ALUSEL_W'(SEL_NOP);
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      aluop_q   <= ALUOP_W'(dec.aluop);
      alusel_q  <= ALUSEL_W'(dec.alusel);
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      wd_q      <= REG_AW'(dec.wd);
      wreg_q    <= dec.wreg;
      pc_q      <= pc_i;
      illegal_q <= dec.illegal;
    end else if (ex_ready_i) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
    end
  end

  assign id_valid_o = valid_q;
  assign aluop_o    = aluop_q;
  assign alusel_o   = alusel_q;
  assign reg1_o     = reg1_q;
  assign reg2_o     = reg2_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q;
  assign pc_o       = pc_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: vector table plus hold/flush/reset sequences.
module tb_id_fwd_stage;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i, if_ready_o;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, ex_ready_i;
  logic        id_valid_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, illegal_o, stall_req_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_fwd_stage dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .id_valid_o(id_valid_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .pc_o(pc_o), .illegal_o(illegal_o), .stall_req_o(stall_req_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rf1, rf2;
    logic        exw;
    logic [4:0]  exd;
    logic [31:0] exdat;
    logic        exl;
    logic        mw;
    logic [4:0]  md;
    logic [31:0] mdat;
    logic        e_stall;
    aluop_e      e_op;
    alusel_e     e_sel;
    logic [31:0] e_r1, e_r2;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic        e_ill;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [31:0] inst, input logic [31:0] rf1, input logic [31:0] rf2,
    input logic exw, input logic [4:0] exd, input logic [31:0] exdat, input logic exl,
    input logic mw, input logic [4:0] md, input logic [31:0] mdat,
    input logic st, input aluop_e op, input alusel_e sel,
    input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
    input logic wr, input logic ill);
    vec_t v;
    v.inst = inst; v.rf1 = rf1; v.rf2 = rf2;
    v.exw = exw; v.exd = exd; v.exdat = exdat; v.exl = exl;
    v.mw = mw; v.md = md; v.mdat = mdat;
    v.e_stall = st; v.e_op = op; v.e_sel = sel;
    v.e_r1 = r1; v.e_r2 = r2; v.e_wd = wd; v.e_wreg = wr; v.e_ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v, input logic [31:0] pc);
    inst_i = v.inst; pc_i = pc;
    reg1_data_i = v.rf1; reg2_data_i = v.rf2;
    ex_wreg_i = v.exw; ex_wd_i = v.exd; ex_wdata_i = v.exdat; ex_is_load_i = v.exl;
    mem_wreg_i = v.mw; mem_wd_i = v.md; mem_wdata_i = v.mdat;
  endtask

  task automatic clear_bypass();
    ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"},   32'(id_valid_o), 32'h0);
    chk({tag, " wreg"},    32'(wreg_o),     32'h0);
    chk({tag, " illegal"}, 32'(illegal_o),  32'h0);
    chk({tag, " aluop"},   32'(aluop_o),    32'(ALU_NOP));
    chk({tag, " alusel"},  32'(alusel_o),   32'(SEL_NOP));
    chk({tag, " reg1"},    reg1_o,          32'h0);
    chk({tag, " reg2"},    reg2_o,          32'h0);
    chk({tag, " pc"},      pc_o,            32'h0);
    chk({tag, " wd"},      32'(wd_o),       32'h0);
  endtask

  initial begin
    //     inst          rf1           rf2           exw exd exdat        exl mw md  mdat         st op       sel        r1            r2            wd  wr ill
    vecs[0]  = mk(32'h34018001, 32'h0000DEAD, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_OR,  SEL_LOGIC, 32'h0,        32'h00008001, 1,  1, 0);
    vecs[1]  = mk(32'h2022FFFF, 32'h77,       32'h0,        1, 1, 32'h5,        0, 1, 1, 32'h9,        0, ALU_ADD, SEL_ARITH, 32'h5,        32'hFFFFFFFF, 2,  1, 0);
    vecs[2]  = mk(32'h306500F0, 32'h3333,     32'h0,        1, 5, 32'hBAD,      1, 1, 3, 32'h1234,     0, ALU_AND, SEL_LOGIC, 32'h1234,     32'h000000F0, 5,  1, 0);
    vecs[3]  = mk(32'h38E6ABCD, 32'h11110000, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_XOR, SEL_LOGIC, 32'h11110000, 32'h0000ABCD, 6,  1, 0);
    vecs[4]  = mk(32'h3C081234, 32'hAAAA,     32'hBBBB,     1, 8, 32'h5,        1, 0, 0, 32'h0,        0, ALU_OR,  SEL_LOGIC, 32'h12340000, 32'h0,        8,  1, 0);
    vecs[5]  = mk(32'h00221820, 32'd10,       32'd20,       1, 2, 32'h7,        0, 0, 0, 32'h0,        0, ALU_ADD, SEL_ARITH, 32'd10,       32'h7,        3,  1, 0);
    vecs[6]  = mk(32'h014B4822, 32'd100,      32'd30,       0, 0, 32'h0,        0, 1, 11, 32'h44,      0, ALU_SUB, SEL_ARITH, 32'd100,      32'h44,       9,  1, 0);
    vecs[7]  = mk(32'h01AE6024, 32'hF0F0,     32'hFF00,     0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_AND, SEL_LOGIC, 32'hF0F0,     32'hFF00,     12, 1, 0);
    vecs[8]  = mk(32'h00430825, 32'h1,        32'h2,        1, 3, 32'h66,       0, 1, 3, 32'h77,       0, ALU_OR,  SEL_LOGIC, 32'h1,        32'h66,       1,  1, 0);
    vecs[9]  = mk(32'h00A62026, 32'h5,        32'h6,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_XOR, SEL_LOGIC, 32'h5,        32'h6,        4,  1, 0);
    vecs[10] = mk(32'h01093827, 32'h8,        32'h9,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_NOR, SEL_LOGIC, 32'h8,        32'h9,        7,  1, 0);
    vecs[11] = mk(32'h000B5100, 32'hDEAD,     32'h11,       0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_SLL, SEL_SHIFT, 32'd4,        32'h11,       10, 1, 0);
    vecs[12] = mk(32'h00020FC2, 32'h0,        32'h80000000, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_SRL, SEL_SHIFT, 32'd31,       32'h80000000, 1,  1, 0);
    vecs[13] = mk(32'h000520C3, 32'h0,        32'h12,       0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_SRA, SEL_SHIFT, 32'd3,        32'h12,       4,  1, 0);
    vecs[14] = mk(32'hFC000000, 32'h1,        32'h2,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_NOP, SEL_NOP,   32'h0,        32'h0,        0,  0, 1);
    vecs[15] = mk(32'h002B5100, 32'h1,        32'h2,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_NOP, SEL_NOP,   32'h0,        32'h0,        0,  0, 1);
    vecs[16] = mk(32'h00221801, 32'h1,        32'h2,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, ALU_NOP, SEL_NOP,   32'h0,        32'h0,        0,  0, 1);
    vecs[17] = mk(32'h00021820, 32'h99,       32'h22,       1, 0, 32'h55,       1, 0, 0, 32'h0,        0, ALU_ADD, SEL_ARITH, 32'h0,        32'h22,       3,  1, 0);
    vecs[18] = mk(32'h00221820, 32'd10,       32'd20,       1, 2, 32'h7,        1, 0, 0, 32'h0,        1, ALU_NOP, SEL_NOP,   32'h0,        32'h0,        0,  0, 0);
    vecs[19] = mk(32'h00221820, 32'd10,       32'd20,       1, 2, 32'h7,        0, 0, 0, 32'h0,        0, ALU_ADD, SEL_ARITH, 32'd10,       32'h7,        3,  1, 0);
    vecs[20] = mk(32'h000520C3, 32'h0,        32'h12,       1, 5, 32'h0,        1, 0, 0, 32'h0,        1, ALU_NOP, SEL_NOP,   32'h0,        32'h0,        0,  0, 0);
    vecs[21] = mk(32'h38E6ABCD, 32'h10,       32'h0,        1, 6, 32'h1,        1, 0, 0, 32'h0,        0, ALU_XOR, SEL_LOGIC, 32'h10,       32'h0000ABCD, 6,  1, 0);

    rst = 1'b0; if_valid_i = 1'b0; pc_i = 32'h0; inst_i = 32'h0;
    reg1_data_i = 32'h0; reg2_data_i = 32'h0;
    flush_i = 1'b0; ex_ready_i = 1'b1;
    clear_bypass();
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst = 1'b1;

    // Table: one vector per cycle with EX always ready
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_vec(vecs[i], 32'h1000 + 32'(i) * 4);
      if_valid_i = 1'b1;
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall_req_o), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d if_ready", i), 32'(if_ready_o), 32'(!vecs[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), 32'(id_valid_o), 32'(!vecs[i].e_stall));
      chk($sformatf("v%0d wreg", i), 32'(wreg_o), 32'(vecs[i].e_wreg));
      if (!vecs[i].e_stall) begin
        chk($sformatf("v%0d aluop", i), 32'(aluop_o), 32'(vecs[i].e_op));
        chk($sformatf("v%0d alusel", i), 32'(alusel_o), 32'(vecs[i].e_sel));
        chk($sformatf("v%0d reg1", i), reg1_o, vecs[i].e_r1);
        chk($sformatf("v%0d reg2", i), reg2_o, vecs[i].e_r2);
        chk($sformatf("v%0d wd", i), 32'(wd_o), 32'(vecs[i].e_wd));
        chk($sformatf("v%0d illegal", i), 32'(illegal_o), 32'(vecs[i].e_ill));
        chk($sformatf("v%0d pc", i), pc_o, 32'h1000 + 32'(i) * 4);
      end
    end

    // Hold: SRA stays put while EX is back-pressured, even as inputs change
    @(negedge clk);
    clear_bypass();
    inst_i = 32'h000520C3; pc_i = 32'h2000; reg2_data_i = 32'hF0000000; ex_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("hold load valid", 32'(id_valid_o), 32'h1);
    chk("hold load reg2", reg2_o, 32'hF0000000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ex_ready_i = 1'b0; inst_i = 32'h34018001; pc_i = 32'h3000; reg2_data_i = 32'h1;
      #1 chk($sformatf("hold%0d if_ready", k), 32'(if_ready_o), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d valid", k), 32'(id_valid_o), 32'h1);
      chk($sformatf("hold%0d aluop", k), 32'(aluop_o), 32'(ALU_SRA));
      chk($sformatf("hold%0d reg1", k), reg1_o, 32'd3);
      chk($sformatf("hold%0d reg2", k), reg2_o, 32'hF0000000);
      chk($sformatf("hold%0d wd", k), 32'(wd_o), 32'd4);
      chk($sformatf("hold%0d pc", k), pc_o, 32'h2000);
    end
    @(negedge clk) ex_ready_i = 1'b1;
    #1 chk("release if_ready", 32'(if_ready_o), 32'h1);
    @(posedge clk); #1;
    chk("release aluop", 32'(aluop_o), 32'(ALU_OR));
    chk("release wd", 32'(wd_o), 32'd1);
    chk("release reg2", reg2_o, 32'h00008001);
    chk("release pc", pc_o, 32'h3000);

    // Flush while holding ORI with a valid XOR offered
    @(negedge clk);
    ex_ready_i = 1'b0; flush_i = 1'b1; inst_i = 32'h00A62026; pc_i = 32'h4000;
    @(posedge clk); #1;
    chk("flush held valid", 32'(id_valid_o), 32'h0);
    chk("flush held wreg", 32'(wreg_o), 32'h0);
    // Flush coinciding with an acceptance drops the instruction
    @(negedge clk) ex_ready_i = 1'b1;
    #1 chk("flush acc if_ready", 32'(if_ready_o), 32'h1);
    @(posedge clk); #1;
    chk("flush acc valid", 32'(id_valid_o), 32'h0);
    chk("flush acc wreg", 32'(wreg_o), 32'h0);
    @(negedge clk) flush_i = 1'b0;
    @(posedge clk); #1;
    chk("post flush valid", 32'(id_valid_o), 32'h1);
    chk("post flush aluop", 32'(aluop_o), 32'(ALU_XOR));
    chk("post flush pc", pc_o, 32'h4000);

    // Asynchronous reset mid-stream, away from any clock edge
    @(posedge clk); #3 rst = 1'b0;
    #1 chk_reset("async rst");
    @(negedge clk) begin rst = 1'b1; if_valid_i = 1'b0; end
    @(posedge clk); #1;
    chk("after rst valid", 32'(id_valid_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
